multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, max consecutive cycles a memory state waits for mem_ready before timing out.
REQ-002 clk  input  1  system clock, all state updated on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction register bits [31:26], valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes current read/write this cycle.
REQ-007 pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  standard multicycle datapath controls.
REQ-008 alu_src_b  output  2  00=B reg, 01=constant 1 (word-addressed PC), 10/11=sign-extended imm.
REQ-009 alu_op  output  2  00=add, 01=sub, 10=use funct.
REQ-010 pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 state  output  4  current state encoding, for debug.
REQ-012 illegal_op, mem_timeout  output  1 each  single-cycle error pulses.
REQ-013 instr_retired  output  32  retired-instruction count.

Function
REQ-014 States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; codes 12-15 shall go to FETCH next cycle.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write asserted only in the cycle mem_ready=1, which advances to DECODE; otherwise hold.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 000000->EXECUTE, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EXEC, other->FETCH with illegal_op=1 for that cycle.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_READ (lw) or MEM_WRITE (sw).
REQ-018 MEM_READ: mem_read=1, i_or_d=1; mem_ready=1 -> MEM_WB, else hold.
REQ-019 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-020 MEM_WRITE: mem_write=1, i_or_d=1; mem_ready=1 -> FETCH, else hold.
REQ-021 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH; PC update gated externally by zero.
REQ-023 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-024 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-025 All controls not listed for a state shall be 0.
REQ-026 Wait counter counts consecutive cycles in FETCH/MEM_READ/MEM_WRITE with mem_ready=0; clears on state exit or mem_ready=1.
REQ-027 When wait counter reaches WAIT_LIMIT with mem_ready=0: mem_timeout=1 that cycle, no ir_write/pc_write/reg_write, next state FETCH, counter cleared.
REQ-028 mem_ready=1 in the timeout cycle takes priority: normal completion, no mem_timeout.
REQ-029 instr_retired increments by 1 on exit of MEM_WB, MEM_WRITE (ready), ALU_WB, BRANCH, JUMP, ADDI_WB; wraps 0xFFFFFFFF->0; not incremented on illegal_op or timeout.
REQ-030 Outputs are Moore decodes of state except ir_write, pc_write (FETCH) and mem_timeout, which also depend on mem_ready/counter.

Reset
REQ-031 rst=1 at a clock edge shall force state=FETCH, wait counter=0, instr_retired=0, overriding any in-progress memory wait.
REQ-032 While rst=1, all control outputs and error pulses shall be 0; FETCH controls resume the cycle after rst falls.

Structure
REQ-033 Opcode constants, state encodings, alu_op and pc_source codes shall live in a shared package reused by control and alu_control.
REQ-034 A single sub-module, next_state_decode (combinational next state from state, opcode, mem_ready, timeout), is permitted; registers stay in multicycle_control.

Verification
REQ-035 R-type add, mem_ready tied 1 -> states 0,1,6,7,0; instr_retired 0->1; reg_write=1, reg_dst=1 only in state 7.
REQ-036 lw with mem_ready delayed 3 cycles in MEM_READ -> state holds at 3 for 4 cycles, then 4 with reg_write=1, mem_to_reg=1.
REQ-037 opcode 111111 -> illegal_op pulses one cycle in DECODE, next state 0, instr_retired unchanged.
REQ-038 WAIT_LIMIT=4, mem_ready=0 in FETCH -> mem_timeout pulse on 5th FETCH cycle, no ir_write, state remains/returns 0, counter restarts.
REQ-039 rst asserted mid-MEM_WRITE wait, instr_retired=7 -> next edge state=0, instr_retired=0, mem_write=0.
REQ-040 instr_retired preloaded near 0xFFFFFFFF via 1 retire after forcing -> wraps to 0x00000000.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
//============================================================================
// Module      : multicycle_control_pkg
// Description : Shared encodings for the multicycle controller and ALU control
// Revision    : 1.0
//============================================================================
package multicycle_control_pkg;

    localparam logic [3:0] c_ST_FETCH     = 4'd0;
    localparam logic [3:0] c_ST_DECODE    = 4'd1;
    localparam logic [3:0] c_ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] c_ST_MEM_READ  = 4'd3;
    localparam logic [3:0] c_ST_MEM_WB    = 4'd4;
    localparam logic [3:0] c_ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] c_ST_EXECUTE   = 4'd6;
    localparam logic [3:0] c_ST_ALU_WB    = 4'd7;
    localparam logic [3:0] c_ST_BRANCH    = 4'd8;
    localparam logic [3:0] c_ST_JUMP      = 4'd9;
    localparam logic [3:0] c_ST_ADDI_EXEC = 4'd10;
    localparam logic [3:0] c_ST_ADDI_WB   = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] c_SRCB_REG     = 2'b00;
    localparam logic [1:0] c_SRCB_ONE     = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_DEC = 2'b11;

    // States that stall on memory and are guarded by the wait counter.
    function automatic logic is_mem_wait(input logic [3:0] state);
        return (state == c_ST_FETCH) || (state == c_ST_MEM_READ) ||
               (state == c_ST_MEM_WRITE);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == c_OP_RTYPE) || (op == c_OP_LW) || (op == c_OP_SW) ||
               (op == c_OP_BEQ) || (op == c_OP_J) || (op == c_OP_ADDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_next_state_decode.sv
`default_nettype none
//============================================================================
// Module      : next_state_decode
// Description : Combinational next-state logic for the multicycle controller
// Revision    : 1.0
//============================================================================
module next_state_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    input  logic       i_timeout,
    output logic [3:0] o_next_state
);

    always_comb begin
        o_next_state = c_ST_FETCH;
        case (i_state)
            c_ST_FETCH:     o_next_state = i_mem_ready ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: begin
                case (i_opcode)
                    c_OP_RTYPE:      o_next_state = c_ST_EXECUTE;
                    c_OP_LW, c_OP_SW: o_next_state = c_ST_MEM_ADDR;
                    c_OP_BEQ:        o_next_state = c_ST_BRANCH;
                    c_OP_J:          o_next_state = c_ST_JUMP;
                    c_OP_ADDI:       o_next_state = c_ST_ADDI_EXEC;
                    default:         o_next_state = c_ST_FETCH;
                endcase
            end
            c_ST_MEM_ADDR:  o_next_state = (i_opcode == c_OP_LW) ? c_ST_MEM_READ : c_ST_MEM_WRITE;
            c_ST_MEM_READ: begin
                if (i_mem_ready)    o_next_state = c_ST_MEM_WB;
                else if (i_timeout) o_next_state = c_ST_FETCH;
                else                o_next_state = c_ST_MEM_READ;
            end
            c_ST_MEM_WRITE: o_next_state = (i_mem_ready || i_timeout) ? c_ST_FETCH : c_ST_MEM_WRITE;
            c_ST_EXECUTE:   o_next_state = c_ST_ALU_WB;
            c_ST_ADDI_EXEC: o_next_state = c_ST_ADDI_WB;
            default:        o_next_state = c_ST_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
//============================================================================
// Module      : multicycle_control
// Description : Multicycle datapath controller with memory-wait timeout
// Revision    : 1.0
//============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [31:0] instr_retired
);

    localparam int                 c_CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(WAIT_LIMIT);

    logic [3:0]         r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [31:0]        r_instr_retired;
    logic [3:0]         w_next_state;
    logic               w_waiting;
    logic               w_timeout;
    logic               w_retire;
    logic               w_unused;

    // Branch resolution on zero happens in the datapath, outside this block.
    assign w_unused  = zero;

    assign w_waiting = is_mem_wait(r_state);
    assign w_timeout = w_waiting && !mem_ready && (r_wait_cnt >= c_LIMIT);

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            c_ST_MEM_WB, c_ST_ALU_WB, c_ST_BRANCH,
            c_ST_JUMP, c_ST_ADDI_WB: w_retire = 1'b1;
            c_ST_MEM_WRITE:          w_retire = mem_ready;
            default:                 w_retire = 1'b0;
        endcase
    end

    next_state_decode u_next_state_decode (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_mem_ready  (mem_ready),
        .i_timeout    (w_timeout),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_FETCH;
            r_wait_cnt      <= '0;
            r_instr_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_waiting && !mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_retire)
                r_instr_retired <= r_instr_retired + 32'd1;
        end
    end

    // Moore decode of r_state; held at zero while reset is asserted.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = c_SRCB_REG;
        alu_op        = c_ALUOP_ADD;
        pc_source     = c_PCSRC_ALU;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        if (!rst) begin
            mem_timeout = w_timeout;
            case (r_state)
                c_ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = c_SRCB_ONE;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                c_ST_DECODE: begin
                    alu_src_b  = c_SRCB_IMM_DEC;
                    illegal_op = !is_legal_op(opcode);
                end
                c_ST_MEM_ADDR, c_ST_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = c_SRCB_IMM;
                end
                c_ST_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                c_ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                c_ST_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                c_ST_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = c_ALUOP_FUNCT;
                end
                c_ST_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                c_ST_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = c_ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = c_PCSRC_ALUOUT;
                end
                c_ST_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = c_PCSRC_JUMP;
                end
                c_ST_ADDI_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign state         = r_state;
    assign instr_retired = r_instr_retired;

endmodule
`default_nettype wire
